mant_mult_seq: RTL

//  Iterative, parametrised unsigned mantissa multiplier: the sequential successor to the combinational 24x24 product stage.

---
 rtl/mant_mult_seq_if.sv | 24 ++
 rtl/mant_mult_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/mant_mult_seq_if.sv
// Operand/result handshake bundle for the sequential mantissa multiplier.
// Valid/ready: a transfer happens on a rising edge where valid && ready; a producer holds its
// payload stable while valid is high and ready is low, and valid may not wait on ready.
interface mant_mult_seq_if #(
  parameter int WIDTH = 24
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/mant_mult_seq.sv
// Iterative unsigned shift-add mantissa multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Legal BITS_PER_CYCLE values are 1, 2 and 4, and WIDTH must be a multiple of BITS_PER_CYCLE.
module mant_mult_seq #(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mant_mult_seq_if.slave       bus,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand_sh;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] prod_q;
  logic               out_valid_q;

  logic [2*WIDTH-1:0] digit_ext;
  logic [2*WIDTH-1:0] partial;

  // mcand_sh is pre-shifted each step, so the partial product already carries
  // the count*BITS_PER_CYCLE weight and needs no variable shifter.
  always_comb begin
    digit_ext = '0;
    digit_ext[BITS_PER_CYCLE-1:0] = mplier[BITS_PER_CYCLE-1:0];
    partial = mcand_sh * digit_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mcand_sh    <= '0;
      mplier      <= '0;
      acc         <= '0;
      count       <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand_sh <= {{WIDTH{1'b0}}, bus.in_a};
            mplier   <= bus.in_b;
            acc      <= '0;
            count    <= '0;
            if (bus.in_a == '0 || bus.in_b == '0) begin
              state       <= S_DONE;
              prod_q      <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // After N steps the accumulator is complete; publish it on the following edge.
          if (count == LAST) begin
            state       <= S_DONE;
            prod_q      <= acc;
            out_valid_q <= 1'b1;
          end else begin
            acc      <= acc + partial;
            mplier   <= mplier >> BITS_PER_CYCLE;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            count    <= count + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = prod_q;
  assign busy          = (state == S_CALC) || (state == S_DONE);
  assign dbg_state     = state;

endmodule
